// File: rtl/receptor_pacote_uart_if.sv
// Signal bundle between the UART packet receiver and whatever drives its
// serial line and consumes its packets.
interface receptor_pacote_uart_if;
    logic        rx;
    logic [15:0] pacote;
    logic [7:0]  comando;
    logic [7:0]  valor;
    logic        pacote_valido;
    logic        alarme;
    logic        erro_frame;
    logic [3:0]  state;

    modport master (
        output rx,
        input  pacote, comando, valor, pacote_valido, alarme, erro_frame, state
    );

    modport slave (
        input  rx,
        output pacote, comando, valor, pacote_valido, alarme, erro_frame, state
    );
endinterface

// File: rtl/receptor_pacote_uart.sv
// UART receiver for 16-bit sensor packets (start + 16 data LSB-first + stop),
// splitting each packet into command/value bytes with alarm classification.
module receptor_pacote_uart #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  ALARM_CODE   = 8'h37
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    receptor_pacote_uart_if.slave  bus
);
    localparam int TICK_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] TICK_HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'b0000,
        START     = 4'b0001,
        DATA      = 4'b0010,
        STOP      = 4'b0011,
        DONE      = 4'b0100,
        WAIT_IDLE = 4'b0101
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic                erro_q, erro_d;
    logic [15:0]         shift_q;
    logic [15:0]         pacote_q;
    logic                alarme_q;
    logic                sync1_q, rxs_q;
    logic                sample_bit;
    logic                load_pacote;

    // State register plus datapath; everything freezes while clk_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            erro_q   <= 1'b0;
            shift_q  <= '0;
            pacote_q <= '0;
            alarme_q <= 1'b0;
            sync1_q  <= 1'b1;
            rxs_q    <= 1'b1;
        end else if (clk_en) begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            erro_q  <= erro_d;
            sync1_q <= bus.rx;
            rxs_q   <= sync1_q;
            if (sample_bit) begin
                shift_q[bit_q] <= rxs_q;
            end
            if (load_pacote) begin
                pacote_q <= shift_q;
                alarme_q <= (shift_q[15:8] == ALARM_CODE);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        erro_d      = 1'b0;
        sample_bit  = 1'b0;
        load_pacote = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick_q == TICK_HALF_LAST) begin
                    tick_d = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    if (!rxs_q) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_q == TICK_BIT_LAST) begin
                    tick_d     = '0;
                    sample_bit = 1'b1;
                    if (bit_q == 4'd15) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_q == TICK_BIT_LAST) begin
                    tick_d = '0;
                    if (rxs_q) begin
                        state_d     = DONE;
                        load_pacote = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                        erro_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DONE:      state_d = IDLE;
            WAIT_IDLE: if (rxs_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pacote        = pacote_q;
        bus.comando       = pacote_q[15:8];
        bus.valor         = pacote_q[7:0];
        bus.alarme        = alarme_q;
        bus.pacote_valido = clk_en && (state_q == DONE);
        bus.erro_frame    = clk_en && erro_q;
        bus.state         = state_q;
    end
endmodule

// File: doc/receptor_pacote_uart.md
Name: receptor_pacote_uart

Overview:
- Serial receiver that sits directly upstream of the packet verifier in the sensor-polling path.
- Samples the sensor `rx` line and reassembles one 16-bit sensor packet per UART frame: 1 start bit, 16 data bits LSB-first, 1 stop bit.
- Each packet is delivered as a one-cycle valid pulse, split into command byte and value byte, with alarm-code classification.
- Exposes its FSM state for the 4-bit debug bus used by the other stages.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 2.
- ALARM_CODE, 8'h37, command byte that marks an alarm packet.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clk_en  input  1  clock enable; when low, all state is frozen
- rx  input  1  asynchronous serial line, idle high
- pacote  output  16  last correctly received packet
- comando  output  8  pacote[15:8]
- valor  output  8  pacote[7:0]
- pacote_valido  output  1  one-cycle pulse: new packet on `pacote`
- alarme  output  1  high while `comando == ALARM_CODE`; updated with `pacote`
- erro_frame  output  1  one-cycle pulse: stop bit sampled low
- state  output  4  current FSM state encoding

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Outputs on reset: pacote=0, comando=0, valor=0, pacote_valido=0, alarme=0, erro_frame=0, state=IDLE.
  - Internal on reset: bit counter=0, tick counter=0, synchronizer flops=1.
  - Reset takes priority over clk_en and aborts any frame in progress; no pulse is emitted.
- Synchronizer: 2-flop synchronizer on `rx`; `rxs` is its output. All decisions use `rxs` (2-cycle latency from pin).
- clk_en low: state, counters, shift register and synchronizer all hold. Pulse outputs are driven 0 on any clk_en-low cycle. Frame timing stretches by the number of disabled cycles.
- FSM encodings: IDLE=4'b0000, START=4'b0001, DATA=4'b0010, STOP=4'b0011, DONE=4'b0100, WAIT_IDLE=4'b0101.
- IDLE: on `rxs==0`, go to START with tick=0.
- START: count to CLKS_PER_BIT/2-1 (mid-bit), then sample.
  - If `rxs==0`: go to DATA with tick=0, bit=0.
  - Else (glitch): return to IDLE with no output.
- DATA: count to CLKS_PER_BIT-1, then sample `rxs` into shift[bit].
  - If bit==15, go to STOP; else bit+1.
  - Sampling is therefore at each bit centre.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - If `rxs==1`: go to DONE. pacote/comando/valor/alarme load from the shift register on this edge.
  - Else: erro_frame=1 for one cycle, pacote unchanged, go to WAIT_IDLE.
- DONE: pacote_valido=1 for exactly this cycle, then go to IDLE.
  - A falling `rxs` in DONE is not lost: the next frame starts from IDLE one cycle later.
  - Next-frame timing starts at IDLE, so senders must keep the stop bit >= 1 bit-time.
- WAIT_IDLE: stay until `rxs==1`, then go to IDLE. Prevents a stuck-low line from being taken as back-to-back frames.
- Latency: pacote_valido rises 2 + CLKS_PER_BIT/2 + 17·CLKS_PER_BIT + 1 cycles after the start-bit falling edge at the pin. With clk_en=1 and CLKS_PER_BIT=4 this is 73 cycles.
- Width rules: tick counter is $clog2(CLKS_PER_BIT) bits; bit counter is 4 bits, with 15 as terminal value (no wrap into the next frame).
- Hold rules:
  - `alarme` stays at its value until the next valid packet; it is never cleared by erro_frame.
  - pacote_valido and erro_frame are never high in the same cycle.

Test Plan (CLKS_PER_BIT=4, clk_en=1 unless stated):
1. Frame 0x3205 (LSB-first, stop=1) → one pacote_valido pulse; pacote=16'h3205, comando=8'h32, valor=8'h05, alarme=0; state sequence 0→1→2→3→4→0.
2. Frame 0x3700 immediately after frame 0x3205 (one stop-bit gap) → two valid pulses; final pacote=16'h3700, alarme=1.
3. rx low for 1 cycle only, then high → state returns to 0 from 1 with no pulses; pacote unchanged.
4. Frame 0x1234 with stop bit=0, then rx held low 20 cycles → erro_frame pulse once; pacote keeps prior value; state=5 until rx high, then 0.
5. Assert reset for one cycle in the middle of DATA (bit 7) → next cycle state=0, all outputs 0. A following full frame 0xABCD is received correctly.
6. Frame 0x3205 with clk_en low for 10 cycles during DATA → pacote=16'h3205 is still received. Valid pulse arrives 10 cycles later than in scenario 1; no pulses appear while clk_en is low.
